// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package enc_pkg;

  // Default number of request bits.
  localparam int WIDTH = 8;

  // Ceiling log2. Usable in constant expressions such as parameter widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Value that the output index takes in reset.
  localparam int IDX_W_DEF = clog2(WIDTH);
  localparam logic [IDX_W_DEF-1:0] IDX_RESET = '0;

endpackage : enc_pkg

// File: rtl/prio_enc_comb.sv
// Combinational highest-set-bit encoder built as a halving OR-reduction tree.
// At each level the upper half of the surviving window is OR-reduced. If any
// upper bit is set, that half survives and the index bit is 1. Otherwise the
// lower half survives. After log2(WIDTH) levels one bit remains, and that bit
// equals |a.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int WIDTH = enc_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]             a,
  output logic [enc_pkg::clog2(WIDTH)-1:0] idx,
  output logic                         vld
);

  localparam int IDX_W = clog2(WIDTH);

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] mask;

  // Walk the tree from the widest level down to a single surviving bit.
  always_comb begin
    // NOTE: give every combinational output a default before any branch, so
    // that no path leaves it unassigned and infers a latch.
    cur   = a;
    idx   = '0;
    upper = '0;
    mask  = '0;
    for (int l = IDX_W - 1; l >= 0; l--) begin
      mask   = (WIDTH'(1) << (1 << l)) - WIDTH'(1);
      upper  = (cur >> (1 << l)) & mask;
      idx[l] = |upper;
      cur    = idx[l] ? upper : (cur & mask);
    end
    vld = cur[0];
  end

endmodule : prio_enc_comb

// File: rtl/if_enc8_3.sv
// Registered 8-to-3 priority encoder. The index of the highest set request bit
// and a valid flag are presented from flops one clock after sampling.
module if_enc8_3
  import enc_pkg::*;
#(
  parameter int WIDTH = enc_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]                  A,
  output logic [enc_pkg::clog2(WIDTH)-1:0]  Y,
  output logic                              Valid,
  input  logic                              clk,
  input  logic                              rst
);

  localparam int IDX_W = clog2(WIDTH);

  logic [IDX_W-1:0] enc_idx_d;
  logic             enc_vld_d;
  logic [IDX_W-1:0] y_q;
  logic             valid_q;

  prio_enc_comb #(
    .WIDTH (WIDTH)
  ) u_prio_enc_comb (
    .a   (A),
    .idx (enc_idx_d),
    .vld (enc_vld_d)
  );

  // Capture the encoded result on every edge. Reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      y_q     <= IDX_W'(IDX_RESET);
      valid_q <= 1'b0;
    end else begin
      y_q     <= enc_idx_d;
      valid_q <= enc_vld_d;
    end
  end

  assign Y     = y_q;
  assign Valid = valid_q;

endmodule : if_enc8_3

// File: tb/tb_if_enc8_3.sv
// Self-checking bench for if_enc8_3: directed steps with a scoreboard queue.
module tb_if_enc8_3;

  logic [7:0] A;
  logic [2:0] Y;
  logic       Valid;
  logic       clk;
  logic       rst;

  typedef struct packed {
    logic [2:0] y;
    logic       v;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  if_enc8_3 dut (
    .A     (A),
    .Y     (Y),
    .Valid (Valid),
    .clk   (clk),
    .rst   (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: this is a linear scan where the last set bit wins.
  function automatic exp_t ref_enc(input logic [7:0] a);
    exp_t e;
    e.y = 3'd0;
    e.v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) begin
        e.y = 3'(i);
        e.v = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [2:0] y_exp, input logic v_exp);
    vectors++;
    assert (Y === y_exp && Valid === v_exp)
    else begin
      miscompares++;
      $error("FAIL %s: got Y=%0d Valid=%b, want Y=%0d Valid=%b", tag, Y, Valid, y_exp, v_exp);
    end
  endtask

  // Drive one vector between edges, push its expectation, and compare after the edge.
  task automatic apply(input string tag, input logic [7:0] a);
    exp_t e;
    @(negedge clk);
    A = a;
    sb_q.push_back(ref_enc(a));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, e.y, e.v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all requests high and no clock edge yet.
    rst = 1'b1;
    A   = 8'hFF;
    #1;
    check("reset_async", 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply("reset_release_ff", 8'hFF);

    apply("zero", 8'h00);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << i;
      apply($sformatf("onehot_%0d", i), oh);
    end

    apply("prio_0a", 8'h0A);
    check("prio_0a_const", 3'd3, 1'b1);
    apply("prio_81", 8'h81);
    check("prio_81_const", 3'd7, 1'b1);
    apply("prio_7e", 8'h7E);
    check("prio_7e_const", 3'd6, 1'b1);

    // Mid-stream reset between edges.
    apply("mid_10", 8'h10);
    @(negedge clk);
    A = 8'h80;
    rst = 1'b1;
    #1;
    check("mid_rst_async", 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("mid_rst_hold", 3'd0, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Glitch between edges: only the value present at the edge is captured.
    @(negedge clk);
    A = 8'h80;
    #2;
    A = 8'h02;
    sb_q.push_back(ref_enc(8'h02));
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e = sb_q.pop_front();
      check("glitch", e.y, e.v);
    end

    // All 256 input values, checked one cycle later against the model.
    for (int v = 0; v < 256; v++) begin
      apply($sformatf("exh_%02h", v), 8'(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_if_enc8_3
